// File: rtl/pulse_height_analyzer.sv
// Pulse height analyzer for trapezoidal-filter output: threshold/hysteresis pulse detection,
// flat-top peak capture, and one event per pulse over valid/ready, with counted drops.
module pulse_height_analyzer #(
    parameter int DATA_WIDTH = 16,
    parameter int THRESHOLD  = 100,
    parameter int HYST       = 10,
    parameter int HOLDOFF    = 4,
    parameter int MAX_WIDTH  = 64,
    parameter int TS_WIDTH   = 32,
    parameter int WIDTH_BITS = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic signed [DATA_WIDTH-1:0] ev_amplitude,
    output logic [TS_WIDTH-1:0]          ev_timestamp,
    output logic [WIDTH_BITS-1:0]        ev_width,
    output logic                         ev_pileup,
    output logic [CNT_WIDTH-1:0]         drop_count
);

    localparam logic signed [DATA_WIDTH-1:0] THR_HI = DATA_WIDTH'(THRESHOLD);
    localparam logic signed [DATA_WIDTH-1:0] THR_LO = DATA_WIDTH'(THRESHOLD - HYST);
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HO_W-1:0] HO_INIT = HO_W'(HOLDOFF);
    // A MAX_WIDTH beyond the saturating width range can never be reached.
    localparam int MAXW_CLAMP = (MAX_WIDTH > (1 << WIDTH_BITS)) ? (1 << WIDTH_BITS) : MAX_WIDTH;
    localparam logic [WIDTH_BITS:0] MAXW = (WIDTH_BITS + 1)'(MAXW_CLAMP);

    typedef enum logic [1:0] {StIdle, StPulse, StHoldoff} state_t;

    state_t                         r_state, w_state_next;
    logic [TS_WIDTH-1:0]            r_ts_cnt;
    logic signed [DATA_WIDTH-1:0]   r_peak, w_peak_next;
    logic [TS_WIDTH-1:0]            r_peak_ts, w_peak_ts_next;
    logic [WIDTH_BITS-1:0]          r_width, w_width_next, w_width_inc;
    logic                           r_pileup, w_pileup_next;
    logic [HO_W-1:0]                r_ho_cnt, w_ho_next;
    logic                           w_emit, w_load;

    logic                           r_ev_valid;
    logic signed [DATA_WIDTH-1:0]   r_ev_amp;
    logic [TS_WIDTH-1:0]            r_ev_ts;
    logic [WIDTH_BITS-1:0]          r_ev_width;
    logic                           r_ev_pileup;
    logic [CNT_WIDTH-1:0]           r_drop_cnt;

    assign w_width_inc = (r_width == '1) ? r_width : r_width + WIDTH_BITS'(1);

    always_comb begin
        w_state_next   = r_state;
        w_peak_next    = r_peak;
        w_peak_ts_next = r_peak_ts;
        w_width_next   = r_width;
        w_pileup_next  = r_pileup;
        w_ho_next      = r_ho_cnt;
        w_emit         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_valid && (in_data > THR_HI)) begin
                    w_peak_next    = in_data;
                    w_peak_ts_next = r_ts_cnt;
                    w_width_next   = WIDTH_BITS'(1);
                    w_pileup_next  = 1'b0;
                    w_state_next   = StPulse;
                end
            end
            StPulse: begin
                if (in_valid) begin
                    if (in_data <= THR_LO) begin
                        // End sample is not part of the pulse; current registers form the event.
                        w_emit = 1'b1;
                        if (HOLDOFF == 0) begin
                            w_state_next = StIdle;
                        end else begin
                            w_state_next = StHoldoff;
                            w_ho_next    = HO_INIT;
                        end
                    end else begin
                        w_width_next = w_width_inc;
                        if (in_data > r_peak) begin
                            w_peak_next    = in_data;
                            w_peak_ts_next = r_ts_cnt;
                        end
                        if ({1'b0, w_width_inc} >= MAXW) begin
                            w_pileup_next = 1'b1;
                        end
                    end
                end
            end
            StHoldoff: begin
                if (r_ho_cnt <= HO_W'(1)) begin
                    w_state_next = StIdle;
                end else begin
                    w_ho_next = r_ho_cnt - HO_W'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_ts_cnt  <= '0;
            r_peak    <= '0;
            r_peak_ts <= '0;
            r_width   <= '0;
            r_pileup  <= 1'b0;
            r_ho_cnt  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ts_cnt  <= r_ts_cnt + TS_WIDTH'(1);
            r_peak    <= w_peak_next;
            r_peak_ts <= w_peak_ts_next;
            r_width   <= w_width_next;
            r_pileup  <= w_pileup_next;
            r_ho_cnt  <= w_ho_next;
        end
    end

    // Loading is allowed in the same cycle the held event is consumed.
    assign w_load = w_emit && (!r_ev_valid || ev_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ev_valid  <= 1'b0;
            r_ev_amp    <= '0;
            r_ev_ts     <= '0;
            r_ev_width  <= '0;
            r_ev_pileup <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (w_load) begin
            r_ev_valid  <= 1'b1;
            r_ev_amp    <= r_peak;
            r_ev_ts     <= r_peak_ts;
            r_ev_width  <= r_width;
            r_ev_pileup <= r_pileup;
        end else if (w_emit) begin
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
        end else if (r_ev_valid && ev_ready) begin
            r_ev_valid <= 1'b0;
        end
    end

    assign ev_valid     = r_ev_valid;
    assign ev_amplitude = r_ev_amp;
    assign ev_timestamp = r_ev_ts;
    assign ev_width     = r_ev_width;
    assign ev_pileup    = r_ev_pileup;
    assign drop_count   = r_drop_cnt;

endmodule
